dvp_sensor_model: RTL and testbench
===================================

// Module: dvp_sensor_model
// PURPOSE
//  Synthesisable, parametrised emulator of an OV7670-style DVP camera output (pclk/vsync/href/data).
//  Replaces free-running hand-written stimulus: exact, configurable frame geometry, selectable test patterns.
//  Drives video_top's camera inputs in benches and in on-board loopback (camera unplugged).
//  Frame/line timing is deterministic so capture, framebuffer and VGA paths can be checked pixel-exact.
// PARAMETERS
//  H_ACTIVE     640  active pixels per line
//  V_ACTIVE     480  active lines per frame
//  BPP            2  bytes per pixel (1 or 2); 2 = RGB565, high byte first
//  H_BLANK      144  pclk periods with href low after each active line
//  VSYNC_LINES    3  line-times with vsync high
//  V_BACK        17  idle line-times between vsync fall and first active line
//  V_FRONT       10  idle line-times after last active line
//  PCLK_DIV       2  pclk half-period in clk_i cycles (>=1)
// PORTS
//  clk_i          in   1   system clock
//  rst_n_i        in   1   asynchronous, active-low reset
//  enable_i       in   1   level; high = generate frames continuously
//  mode_i         in   2   pattern: 0 colour bars, 1 horizontal ramp, 2 checker, 3 byte counter
//  pclk_o         out  1   emulated pixel clock
//  vsync_o        out  1   frame sync, active high
//  href_o         out  1   line valid, active high
//  data_o         out  8   pixel byte
//  frame_start_o  out  1   one clk_i pulse on the cycle vsync_o rises
//  frame_cnt_o    out 16   completed frames, wraps 0xFFFF->0
//  busy_o         out  1   high from frame start until return to IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters 0. Reset asserted mid-frame clears immediately (async).
//  pclk_o toggles every PCLK_DIV clk_i cycles while not IDLE (period 2*PCLK_DIV); held 0 in IDLE.
//  vsync_o/href_o/data_o change only on the clk_i cycle pclk_o falls -> stable at pclk_o rise.
//  Line-time LT = H_ACTIVE*BPP + H_BLANK pclk periods; every state counts in LT units.
//  FSM: IDLE -(enable_i)-> VSYNC (VSYNC_LINES*LT) -> VBACK (V_BACK*LT) -> ACTIVE (V_ACTIVE*LT)
//       -> VFRONT (V_FRONT*LT) -> VSYNC if enable_i else IDLE.
//  IDLE->VSYNC: vsync_o=1 on first pclk fall; frame_start_o pulses that cycle; mode_i latched here only.
//  ACTIVE line: href_o=1 for first H_ACTIVE*BPP pclk, then 0 for H_BLANK; data_o=0 while href_o=0.
//  enable_i falling mid-frame: current frame completes through VFRONT, then IDLE (no truncated frame).
//  frame_cnt_o increments on VFRONT exit (one cycle, registered); wraps modulo 2^16.
//  Pixel value (x = pixel index, y = active line, both from 0; 16-bit RGB565, BPP=1 emits low byte):
//   0 bars:  8 equal bars, bar = x*8/H_ACTIVE (integer); colours W,Y,C,G,M,R,B,K from package table
//   1 ramp:  {x[4:0], x[5:0], x[4:0]}
//   2 check: 8x8 cells, (x[3]^y[3]) ? 16'hFFFF : 16'h0000
//   3 count: data_o = byte index within frame mod 256 (ignores BPP pairing); resets each frame
//  Counters sized $clog2 of their maxima; no arithmetic overflow for any legal parameter set.
//  busy_o = (state != IDLE).
// STRUCTURE
//  cam_pkg: mode enum (MODE_BARS..MODE_COUNT), FSM state enum, 8-entry RGB565 bar colour table.
//  Sub-module dvp_pattern_gen: combinational (x, y, byte_sel, mode, byte_cnt) -> data byte.
//  Top holds FSM, pclk divider, pclk/line/byte counters, output registers.
// TESTING (bench params: H_ACTIVE=8,V_ACTIVE=4,BPP=2,H_BLANK=4,VSYNC_LINES=1,V_BACK=1,V_FRONT=1,PCLK_DIV=2)
//  1 reset, enable_i=0 -> all outputs 0, pclk_o static for 1000 cycles; busy_o=0.
//  2 enable_i=1 one frame -> vsync_o high 20 pclk; 4 href pulses of 16 pclk each, 4 pclk gaps;
//    frame period 140 pclk = 560 clk_i; frame_start_o single pulse; frame_cnt_o 0->1.
//  3 mode_i=0 -> line bytes (hi,lo) per pixel = FFFF,FFFF? no: bar per pixel: W,Y,C,G,M,R,B,K;
//    first two bytes FF,FF; last two 00,00; all 4 lines identical.
//  4 mode_i=3 -> data_o sequence 00..3F across the frame's 64 href bytes; restarts at 00 next frame.
//  5 enable_i dropped during ACTIVE line 2 -> frame completes, VFRONT finishes, IDLE; frame_cnt_o +1.
//  6 rst_n_i asserted mid ACTIVE -> outputs 0 same cycle; after release+enable, clean frame from VSYNC.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and the colour-bar palette for the DVP camera emulator.
package cam_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  // RGB565 bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [15:0] barColour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational test-pattern source: maps pixel position and byte phase to one data byte.
module dvp_pattern_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        hi_i,
  input  mode_e       mode_i,
  input  logic [7:0]  byte_cnt_i,
  output logic [7:0]  data_o
);

  logic [15:0] pixel;

  always_comb begin
    pixel = 16'h0000;
    case (mode_i)
      MODE_BARS:  pixel = barColour(3'(({x_i, 3'b000}) / 19'(H_ACTIVE)));
      MODE_RAMP:  pixel = {x_i[4:0], x_i[5:0], x_i[4:0]};
      MODE_CHECK: pixel = (|((x_i ^ y_i) & 16'h0008)) ? 16'hFFFF : 16'h0000;
      default:    pixel = 16'h0000;
    endcase
    data_o = (mode_i == MODE_COUNT) ? byte_cnt_i
                                    : (hi_i ? pixel[15:8] : pixel[7:0]);
  end

endmodule

// File: rtl/dvp_sensor_model.sv
// OV7670-style DVP emulator: pclk divider, frame/line sequencer and registered sync/data outputs.
module dvp_sensor_model
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BPP         = 2,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [1:0]  mode_i,
  output logic        pclk_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  data_o,
  output logic        frame_start_o,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o
);

  localparam int LT        = H_ACTIVE * BPP + H_BLANK;
  localparam int HBYTES    = H_ACTIVE * BPP;
  localparam int MAX_VS    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_AF    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES = (MAX_VS > MAX_AF) ? MAX_VS : MAX_AF;
  localparam int PIX_W     = (LT > 1) ? $clog2(LT) : 1;
  localparam int LINE_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam int DIV_W     = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LT - 1);
  localparam logic [PIX_W:0]   HBYTES_C = (PIX_W + 1)'(HBYTES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [PIX_W-1:0]  pixCnt_q, pixCnt_d;
  logic [LINE_W-1:0] lineCnt_q, lineCnt_d;
  logic [DIV_W-1:0]  divCnt_q, divCnt_d;
  logic [7:0]        byteCnt_q, byteCnt_d;
  logic [15:0]       frameCnt_q, frameCnt_d;
  logic              pclk_q, pclk_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        data_q, data_d;
  logic              frameStart_q, frameStart_d;
  logic              outUpdate;
  logic [7:0]        patData;

  function automatic logic [LINE_W-1:0] lastLine(input state_e s);
    case (s)
      ST_VSYNC:  return LINE_W'(VSYNC_LINES - 1);
      ST_VBACK:  return LINE_W'(V_BACK - 1);
      ST_ACTIVE: return LINE_W'(V_ACTIVE - 1);
      ST_VFRONT: return LINE_W'(V_FRONT - 1);
      default:   return '0;
    endcase
  endfunction

  // All timing advances on pclk falling; IDLE exit counts as the first fall of the frame.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pixCnt_d     = pixCnt_q;
    lineCnt_d    = lineCnt_q;
    divCnt_d     = divCnt_q;
    pclk_d       = pclk_q;
    frameCnt_d   = frameCnt_q;
    frameStart_d = 1'b0;
    outUpdate    = 1'b0;
    if (state_q == ST_IDLE) begin
      pclk_d   = 1'b0;
      divCnt_d = '0;
      if (enable_i) begin
        state_d      = ST_VSYNC;
        mode_d       = mode_e'(mode_i);
        pixCnt_d     = '0;
        lineCnt_d    = '0;
        frameStart_d = 1'b1;
        outUpdate    = 1'b1;
      end
    end else if (divCnt_q != DIV_LAST) begin
      divCnt_d = divCnt_q + DIV_W'(1);
    end else begin
      divCnt_d = '0;
      pclk_d   = ~pclk_q;
      if (pclk_q) begin
        outUpdate = 1'b1;
        if (pixCnt_q != PIX_LAST) begin
          pixCnt_d = pixCnt_q + PIX_W'(1);
        end else begin
          pixCnt_d = '0;
          if (lineCnt_q != lastLine(state_q)) begin
            lineCnt_d = lineCnt_q + LINE_W'(1);
          end else begin
            lineCnt_d = '0;
            case (state_q)
              ST_VSYNC:  state_d = ST_VBACK;
              ST_VBACK:  state_d = ST_ACTIVE;
              ST_ACTIVE: state_d = ST_VFRONT;
              ST_VFRONT: begin
                frameCnt_d = frameCnt_q + 16'd1;
                if (enable_i) begin
                  state_d      = ST_VSYNC;
                  frameStart_d = 1'b1;
                end else begin
                  state_d = ST_IDLE;
                end
              end
              default:   state_d = ST_IDLE;
            endcase
          end
        end
      end
    end
  end

  dvp_pattern_gen #(
    .H_ACTIVE(H_ACTIVE)
  ) u_pattern (
    .x_i       ((BPP == 2) ? 16'(pixCnt_d >> 1) : 16'(pixCnt_d)),
    .y_i       (16'(lineCnt_d)),
    .hi_i      ((BPP == 2) && !pixCnt_d[0]),
    .mode_i    (mode_q),
    .byte_cnt_i(byteCnt_q),
    .data_o    (patData)
  );

  // Output values are computed for the position being entered, so they land on the pclk fall.
  always_comb begin
    vsync_d   = vsync_q;
    href_d    = href_q;
    data_d    = data_q;
    byteCnt_d = byteCnt_q;
    if (outUpdate) begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && ({1'b0, pixCnt_d} < HBYTES_C);
      data_d  = href_d ? patData : 8'h00;
      if (frameStart_d) begin
        byteCnt_d = 8'h00;
      end else if (href_d) begin
        byteCnt_d = byteCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_BARS;
      pixCnt_q     <= '0;
      lineCnt_q    <= '0;
      divCnt_q     <= '0;
      byteCnt_q    <= 8'h00;
      frameCnt_q   <= 16'h0000;
      pclk_q       <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      frameStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pixCnt_q     <= pixCnt_d;
      lineCnt_q    <= lineCnt_d;
      divCnt_q     <= divCnt_d;
      byteCnt_q    <= byteCnt_d;
      frameCnt_q   <= frameCnt_d;
      pclk_q       <= pclk_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign pclk_o        = pclk_q;
  assign vsync_o       = vsync_q;
  assign href_o        = href_q;
  assign data_o        = data_q;
  assign frame_start_o = frameStart_q;
  assign frame_cnt_o   = frameCnt_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dvp_sensor_model.sv
// Directed bench for dvp_sensor_model on a tiny 8x4 RGB565 frame (line-time 20 pclk, frame 140 pclk).
module tb_dvp_sensor_model;

  localparam int LT = 20;

  logic        clock = 1'b0;
  logic        rstN;
  logic        enable;
  logic [1:0]  modeSel;
  logic        pclkO;
  logic        vsyncO;
  logic        hrefO;
  logic [7:0]  dataO;
  logic        frameStart;
  logic [15:0] frameCnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] capBytes [64];
  logic [7:0] barLine  [16];
  int byteCount, rises, vsyncRises, lastVsyncIdx, hrefPulses, firstHrefIdx;
  int lenBad, gapBad, dataLeak, fsSeen, busyLow;
  int foundFs;
  int pclkToggles, nonZero;
  logic prevPclkIdle;

  dvp_sensor_model #(
    .H_ACTIVE(8), .V_ACTIVE(4), .BPP(2), .H_BLANK(4),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .PCLK_DIV(2)
  ) dut (
    .clk_i        (clock),
    .rst_n_i      (rstN),
    .enable_i     (enable),
    .mode_i       (modeSel),
    .pclk_o       (pclkO),
    .vsync_o      (vsyncO),
    .href_o       (hrefO),
    .data_o       (dataO),
    .frame_start_o(frameStart),
    .frame_cnt_o  (frameCnt),
    .busy_o       (busy)
  );

  always #5 clock = ~clock;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] m);
    @(negedge clock);
    enable  = en;
    modeSel = m;
  endtask

  task automatic waitFrameStart(output int found);
    found = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (frameStart) begin
        found = 1;
        break;
      end
    end
  endtask

  // Samples on the falling clk edge and records bus state at each pclk rise.
  task automatic captureFrame(input int nCycles, input int dropAt);
    logic prevPclk;
    logic prevHref;
    int   curLen;
    int   lastStart;
    byteCount = 0; rises = 0; vsyncRises = 0; lastVsyncIdx = -1; hrefPulses = 0;
    firstHrefIdx = -1; lenBad = 0; gapBad = 0; dataLeak = 0; fsSeen = 0; busyLow = 0;
    prevPclk = pclkO; prevHref = 1'b0; curLen = 0; lastStart = -1;
    for (int c = 1; c <= nCycles; c++) begin
      @(negedge clock);
      if (c == dropAt) enable = 1'b0;
      if (frameStart) fsSeen++;
      if (!busy) busyLow++;
      if (pclkO && !prevPclk) begin
        if (vsyncO) begin
          vsyncRises++;
          lastVsyncIdx = rises;
        end
        if (hrefO) begin
          if (byteCount < 64) capBytes[byteCount] = dataO;
          byteCount++;
          if (!prevHref) begin
            hrefPulses++;
            if (firstHrefIdx < 0) firstHrefIdx = rises;
            else if (rises - lastStart != LT) gapBad++;
            lastStart = rises;
            curLen = 0;
          end
          curLen++;
        end else begin
          if (dataO != 8'h00) dataLeak++;
          if (prevHref && curLen != 16) lenBad++;
        end
        prevHref = hrefO;
        rises++;
      end
      prevPclk = pclkO;
    end
  endtask

  task automatic checkFrameShape(input string name);
    checkOutput({name, " pclk rises"}, rises, 140);
    checkOutput({name, " vsync pclks"}, vsyncRises, 20);
    checkOutput({name, " last vsync pclk"}, lastVsyncIdx, 19);
    checkOutput({name, " href pulses"}, hrefPulses, 4);
    checkOutput({name, " first href pclk"}, firstHrefIdx, 40);
    checkOutput({name, " href length errors"}, lenBad, 0);
    checkOutput({name, " href spacing errors"}, gapBad, 0);
    checkOutput({name, " data outside href"}, dataLeak, 0);
    checkOutput({name, " stray frame_start"}, fsSeen, 0);
    checkOutput({name, " busy low in frame"}, busyLow, 0);
    checkOutput({name, " href bytes"}, byteCount, 64);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    barLine = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    rstN = 1'b1; enable = 1'b0; modeSel = 2'd0;
    #2 rstN = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("reset vsync", int'(vsyncO), 0);
    checkOutput("reset href", int'(hrefO), 0);
    checkOutput("reset data", int'(dataO), 0);
    checkOutput("reset pclk", int'(pclkO), 0);
    checkOutput("reset frame_start", int'(frameStart), 0);
    checkOutput("reset frame_cnt", int'(frameCnt), 0);
    checkOutput("reset busy", int'(busy), 0);

    rstN = 1'b1;
    pclkToggles = 0; nonZero = 0; prevPclkIdle = pclkO;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (pclkO != prevPclkIdle) pclkToggles++;
      prevPclkIdle = pclkO;
      if (vsyncO || hrefO || dataO != 8'h00 || frameStart || busy) nonZero++;
    end
    checkOutput("idle pclk toggles", pclkToggles, 0);
    checkOutput("idle nonzero outputs", nonZero, 0);

    // Frame A: colour bars, enable kept high so frame B follows back to back.
    applyStimulus(1'b1, 2'd0);
    waitFrameStart(foundFs);
    checkOutput("frameA start seen", foundFs, 1);
    checkOutput("frameA vsync at start", int'(vsyncO), 1);
    checkOutput("frameA busy at start", int'(busy), 1);
    checkOutput("frameA cnt at start", int'(frameCnt), 0);
    captureFrame(559, 0);
    checkFrameShape("frameA");
    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("bars byte %0d", i), int'(capBytes[i]), int'(barLine[i % 16]));
    @(negedge clock);
    checkOutput("frameA period start pulse", int'(frameStart), 1);
    checkOutput("frameA cnt after", int'(frameCnt), 1);
    checkOutput("frameB vsync", int'(vsyncO), 1);

    // Frame B: enable dropped during active line 2; frame must still complete.
    captureFrame(559, 330);
    checkFrameShape("frameB");
    checkOutput("frameB first byte", int'(capBytes[0]), 8'hFF);
    checkOutput("frameB last byte", int'(capBytes[63]), 8'h00);
    @(negedge clock);
    checkOutput("frameB cnt after", int'(frameCnt), 2);
    checkOutput("frameB busy after", int'(busy), 0);
    checkOutput("frameB no restart", int'(frameStart), 0);
    checkOutput("frameB pclk idle", int'(pclkO), 0);
    repeat (20) @(negedge clock);
    checkOutput("idle after B busy", int'(busy), 0);
    checkOutput("idle after B pclk", int'(pclkO), 0);

    // Frame C: byte-counter pattern; frame D follows and must restart at 0.
    applyStimulus(1'b1, 2'd3);
    waitFrameStart(foundFs);
    checkOutput("frameC start seen", foundFs, 1);
    captureFrame(559, 0);
    checkFrameShape("frameC");
    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("count byte %0d", i), int'(capBytes[i]), i);
    @(negedge clock);
    checkOutput("frameC period start pulse", int'(frameStart), 1);
    checkOutput("frameC cnt after", int'(frameCnt), 3);

    captureFrame(200, 0);
    checkOutput("frameD bytes so far", byteCount, 10);
    checkOutput("frameD restart byte", int'(capBytes[0]), 0);
    checkOutput("frameD byte 9", int'(capBytes[9]), 9);
    checkOutput("frameD href before reset", int'(hrefO), 1);
    checkOutput("frameD data before reset", int'(dataO), 10);

    // Asynchronous reset in the middle of an active line.
    rstN = 1'b0;
    #1;
    checkOutput("midreset vsync", int'(vsyncO), 0);
    checkOutput("midreset href", int'(hrefO), 0);
    checkOutput("midreset data", int'(dataO), 0);
    checkOutput("midreset pclk", int'(pclkO), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset frame_cnt", int'(frameCnt), 0);
    repeat (3) @(negedge clock);
    rstN = 1'b1;

    waitFrameStart(foundFs);
    checkOutput("frameE start seen", foundFs, 1);
    checkOutput("frameE vsync at start", int'(vsyncO), 1);
    checkOutput("frameE cnt at start", int'(frameCnt), 0);
    captureFrame(559, 100);
    checkFrameShape("frameE");
    for (int i = 0; i < 64; i += 9)
      checkOutput($sformatf("frameE count byte %0d", i), int'(capBytes[i]), i);
    checkOutput("frameE last byte", int'(capBytes[63]), 63);
    @(negedge clock);
    checkOutput("frameE cnt after", int'(frameCnt), 1);
    checkOutput("frameE busy after", int'(busy), 0);
    checkOutput("frameE no restart", int'(frameStart), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
